mul_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational 4x4 unsigned add-tree multiplier among NREQ requesters.
- Each requester presents operands with a valid/ready handshake. The block grants one requester and latches its operands. It drives the shared multiplier for one cycle, then captures the product and returns it with the requester ID through a valid/ready response port.
- The block sits between the requester blocks and the shared multiplier instance. The multiplier stays outside this block and is connected through the mul_* ports.

---
 rtl/mul_share_arb.sv | 134 +++++++++++++
 tb/tb_mul_share_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Round-robin arbiter and sequencer that time-shares one external combinational
// W x W unsigned multiplier among NREQ requesters. Each operation walks
// IDLE -> CALC -> RESP -> IDLE: the winner's operands are latched on
// acceptance, presented to the multiplier for one cycle, and the product is
// returned together with the requester ID on a valid/ready response port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready is a one-hot grant)
//   req_a, req_b        packed operands, requester i at [i*W +: W]
//   mul_a, mul_b        operands to the shared multiplier (0 outside CALC)
//   mul_p               product returned by the shared multiplier
//   rsp_valid/rsp_ready response handshake; rsp_id, rsp_data hold while valid
//   busy                high whenever an operation is in flight
//   ops_cnt             completed responses, wraps modulo 2**CW
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_data,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [CW-1:0]     ops_cnt
);

  // Width of an index into the requester vectors.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic [W-1:0]   op_a, op_b;
  logic [IDW-1:0] op_id;
  logic           accept;
  logic           complete;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin : rr_search
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_valid[PW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  assign accept   = (state == IDLE) && gnt_any;
  assign complete = (state == RESP) && rsp_ready;

  // The grant is gated by rst_n so every output reads 0 while reset is held,
  // even though requesters may already be presenting valid requests.
  assign req_ready = (rst_n && accept) ? (NREQ'(1) << gnt_idx) : '0;
  assign mul_a     = (state == CALC) ? op_a : '0;
  assign mul_b     = (state == CALC) ? op_b : '0;
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_any)   state_nxt = CALC;
      CALC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath registers. A reset mid-operation simply clears everything, so an
  // in-flight operation never produces a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      ops_cnt   <= '0;
    end else begin
      if (accept) begin
        op_a  <= req_a[gnt_idx*W +: W];
        op_b  <= req_b[gnt_idx*W +: W];
        op_id <= gnt_idx;
        ptr   <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == CALC) begin
        rsp_data  <= mul_p;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if (complete) begin
        rsp_valid <= 1'b0;
        ops_cnt   <= ops_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb (NREQ=4, W=4). The bench plays the shared
// multiplier itself; expected responses are pushed to a scoreboard queue at
// acceptance and popped when the DUT raises rsp_valid.
module tb_mul_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int IDW  = 2;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [W-1:0]      mul_a, mul_b;
  logic [2*W-1:0]    mul_p;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic              rsp_ready;
  logic              busy;
  logic [CW-1:0]     ops_cnt;

  mul_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .ops_cnt(ops_cnt)
  );

  // The shared multiplier lives outside the DUT.
  assign mul_p = 8'(mul_a) * 8'(mul_b);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  m_cnt   = '0;
  int          m_ptr   = 0;
  int          prev_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_mul_a"},     32'(mul_a),     0);
    check({tag, "_mul_b"},     32'(mul_b),     0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"},    32'(rsp_id),    0);
    check({tag, "_rsp_data"},  32'(rsp_data),  0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_ops_cnt"},   32'(ops_cnt),   0);
  endtask

  // One full operation. Called #1 after a negedge while the DUT is IDLE;
  // returns #1 after the negedge following completion. hold = cycles of
  // rsp_ready=0 spent in RESP before the consumer accepts.
  task automatic run_op(input string tag, input logic [3:0] v, input logic [15:0] a,
                        input logic [15:0] b, input int g, input int hold,
                        input bit chk_spacing);
    exp_t       e, got;
    logic [3:0] ea, eb, oh;
    ea = a[g*4 +: 4];
    eb = b[g*4 +: 4];
    oh = '0;
    oh[g] = 1'b1;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(oh));
    check({tag, "_idle_busy"}, 32'(busy), 0);
    if (chk_spacing) check({tag, "_spacing"}, 32'(cyc - prev_acc), 3);
    prev_acc = cyc;
    e.id   = g;
    e.data = int'(ea) * int'(eb);
    exp_q.push_back(e);

    @(negedge clk); #1;  // CALC
    check({tag, "_calc_mul_a"}, 32'(mul_a), 32'(ea));
    check({tag, "_calc_mul_b"}, 32'(mul_b), 32'(eb));
    check({tag, "_calc_ready"}, 32'(req_ready), 0);
    check({tag, "_calc_busy"},  32'(busy), 1);
    check({tag, "_calc_rsp_valid"}, 32'(rsp_valid), 0);

    @(negedge clk); #1;  // RESP
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 1);
    check({tag, "_resp_mul_a"}, 32'(mul_a), 0);
    check({tag, "_resp_mul_b"}, 32'(mul_b), 0);
    check({tag, "_resp_ready"}, 32'(req_ready), 0);
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      check({tag, "_rsp_id"},   32'(rsp_id),   32'(got.id));
      check({tag, "_rsp_data"}, 32'(rsp_data), 32'(got.data));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        check({tag, "_hold_valid"}, 32'(rsp_valid), 1);
        check({tag, "_hold_id"},    32'(rsp_id),    32'(got.id));
        check({tag, "_hold_data"},  32'(rsp_data),  32'(got.data));
        check({tag, "_hold_ready"}, 32'(req_ready), 0);
        check({tag, "_hold_busy"},  32'(busy), 1);
      end
    end
    rsp_ready = 1'b1;

    @(negedge clk); #1;  // back in IDLE after completion edge
    m_cnt = m_cnt + 8'd1;
    check({tag, "_done_valid"}, 32'(rsp_valid), 0);
    check({tag, "_done_busy"},  32'(busy), 0);
    check({tag, "_ops_cnt"},    32'(ops_cnt), 32'(m_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with random inputs: all outputs must read 0.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 4'($urandom);
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = 1'($urandom);
      #1;
      check_all_zero("in_reset");
    end
    @(negedge clk);
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check_all_zero("after_reset");

    // Single request from requester 2: 15*15 = 225.
    run_op("single", 4'b0100, 16'h0F00, 16'h0F00, 2, 0, 1'b0);
    check("single_ops_cnt_one", 32'(ops_cnt), 1);

    // Reset during CALC: ptr is 3, so requester 1 wins (3 -> 0 -> 1).
    req_valid = 4'b0010; req_a = 16'h0050; req_b = 16'h0050; rsp_ready = 1'b1;
    #1;
    check("rst_calc_grant", 32'(req_ready), 32'(4'b0010));
    @(negedge clk); #1;
    check("rst_calc_mul_a", 32'(mul_a), 5);
    check("rst_calc_busy",  32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_calc_busy_drop", 32'(busy), 0);
    check("rst_calc_valid_drop", 32'(rsp_valid), 0);
    check("rst_calc_mul_a_drop", 32'(mul_a), 0);
    check("rst_calc_cnt_clear", 32'(ops_cnt), 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rst_no_response", 32'(rsp_valid), 0);
      check("rst_no_busy", 32'(busy), 0);
    end

    // Fairness: all valid, requester i presents a=i+1, b=3. First grant after
    // reset must go to index 0.
    run_op("rr0", 4'b1111, 16'h4321, 16'h3333, 0, 0, 1'b0);
    run_op("rr1", 4'b1111, 16'h4321, 16'h3333, 1, 0, 1'b1);
    run_op("rr2", 4'b1111, 16'h4321, 16'h3333, 2, 0, 1'b1);
    run_op("rr3", 4'b1111, 16'h4321, 16'h3333, 3, 0, 1'b1);
    run_op("rr4", 4'b1111, 16'h4321, 16'h3333, 0, 0, 1'b1);

    // Backpressure: 7*9 = 63 from requester 1 held for 5 cycles; requester 3
    // stays valid and must not be granted meanwhile.
    run_op("bp", 4'b1010, 16'h0070, 16'h0090, 1, 5, 1'b0);

    // Pointer wrap: grant 3 (ptr -> 0), then 1 and 2, then 0 ahead of 1.
    run_op("wrap3", 4'b1000, 16'h2000, 16'h3000, 3, 0, 1'b0);
    run_op("wrap1", 4'b0110, 16'h0340, 16'h0560, 1, 0, 1'b1);
    run_op("wrap2", 4'b0110, 16'h0340, 16'h0560, 2, 0, 1'b1);
    run_op("wrap0", 4'b0011, 16'h0098, 16'h00BA, 0, 0, 1'b1);

    // Operand corners: 0*15 and 15*0.
    run_op("zero_a", 4'b0010, 16'h0000, 16'h00F0, 1, 0, 1'b0);
    run_op("zero_b", 4'b0100, 16'h0F00, 16'h0000, 2, 0, 1'b1);

    // Counter wrap: 12 completions so far; 244 more bring ops_cnt to 256 = 0.
    m_ptr = 3;
    for (int i = 0; i < 244; i++) begin
      run_op("cnt", 4'b1111, 16'($urandom), 16'($urandom), m_ptr, 0, 1'b0);
      m_ptr = (m_ptr + 1) % NREQ;
    end
    check("cnt_wrap_zero", 32'(ops_cnt), 0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
